// File: rtl/mesi_isc_breq_fifos_cntl_n_if.sv
// Signal bundle between the breq FIFO bank controller and its surroundings
// (mbus, per-CPU breq FIFOs, broadcast FIFO).
interface mesi_isc_breq_fifos_cntl_n_if #(
  parameter int unsigned NUM_CPUS         = 4,
  parameter int unsigned MBUS_CMD_WIDTH   = 3,
  parameter int unsigned ADDR_WIDTH       = 32,
  parameter int unsigned BROAD_TYPE_WIDTH = 2,
  parameter int unsigned BROAD_ID_WIDTH   = 7
);
  localparam int unsigned CPU_ID_WIDTH = $clog2(NUM_CPUS);

  logic                                   arb_mode_i;
  logic [NUM_CPUS*MBUS_CMD_WIDTH-1:0]     mbus_cmd_array_i;
  logic [NUM_CPUS-1:0]                    fifo_status_empty_array_i;
  logic [NUM_CPUS-1:0]                    fifo_status_full_array_i;
  logic                                   broad_fifo_status_full_i;
  logic [NUM_CPUS*ADDR_WIDTH-1:0]         broad_addr_array_i;
  logic [NUM_CPUS*BROAD_TYPE_WIDTH-1:0]   broad_type_array_i;
  logic [NUM_CPUS*BROAD_ID_WIDTH-1:0]     broad_id_array_i;
  logic [NUM_CPUS-1:0]                    mbus_ack_array_o;
  logic [NUM_CPUS-1:0]                    fifo_wr_array_o;
  logic [NUM_CPUS-1:0]                    fifo_rd_array_o;
  logic                                   broad_fifo_wr_o;
  logic [ADDR_WIDTH-1:0]                  broad_addr_o;
  logic [BROAD_TYPE_WIDTH-1:0]            broad_type_o;
  logic [CPU_ID_WIDTH-1:0]                broad_cpu_id_o;
  logic [BROAD_ID_WIDTH-1:0]              broad_id_o;
  logic [NUM_CPUS*BROAD_TYPE_WIDTH-1:0]   breq_type_array_o;
  logic [NUM_CPUS*CPU_ID_WIDTH-1:0]       breq_cpu_id_array_o;
  logic [NUM_CPUS*BROAD_ID_WIDTH-1:0]     breq_id_array_o;
  logic [NUM_CPUS-1:0]                    starved_o;

  modport master (
    output arb_mode_i, mbus_cmd_array_i, fifo_status_empty_array_i,
           fifo_status_full_array_i, broad_fifo_status_full_i,
           broad_addr_array_i, broad_type_array_i, broad_id_array_i,
    input  mbus_ack_array_o, fifo_wr_array_o, fifo_rd_array_o, broad_fifo_wr_o,
           broad_addr_o, broad_type_o, broad_cpu_id_o, broad_id_o,
           breq_type_array_o, breq_cpu_id_array_o, breq_id_array_o, starved_o
  );

  modport slave (
    input  arb_mode_i, mbus_cmd_array_i, fifo_status_empty_array_i,
           fifo_status_full_array_i, broad_fifo_status_full_i,
           broad_addr_array_i, broad_type_array_i, broad_id_array_i,
    output mbus_ack_array_o, fifo_wr_array_o, fifo_rd_array_o, broad_fifo_wr_o,
           broad_addr_o, broad_type_o, broad_cpu_id_o, broad_id_o,
           breq_type_array_o, breq_cpu_id_array_o, breq_id_array_o, starved_o
  );
endinterface

// File: rtl/mesi_isc_breq_fifos_cntl_n.sv
// Breq FIFO bank controller for NUM_CPUS channels: acks broadcast mbus commands,
// tags breq entries, and arbitrates non-empty breq FIFOs into the broadcast FIFO.
module mesi_isc_breq_fifos_cntl_n #(
  parameter int unsigned NUM_CPUS         = 4,
  parameter int unsigned CPU_ID_WIDTH     = $clog2(NUM_CPUS),
  parameter int unsigned MBUS_CMD_WIDTH   = 3,
  parameter int unsigned ADDR_WIDTH       = 32,
  parameter int unsigned BROAD_TYPE_WIDTH = 2,
  parameter int unsigned BROAD_ID_WIDTH   = 7,
  parameter int unsigned STARVE_LIMIT     = 8
) (
  input logic                         clk,
  input logic                         rst_n,
  mesi_isc_breq_fifos_cntl_n_if.slave bus
);
  localparam int unsigned BASE_WIDTH = BROAD_ID_WIDTH - CPU_ID_WIDTH;
  localparam logic [MBUS_CMD_WIDTH-1:0]   MESI_ISC_MBUS_CMD_WR_BROAD = MBUS_CMD_WIDTH'(3);
  localparam logic [MBUS_CMD_WIDTH-1:0]   MESI_ISC_MBUS_CMD_RD_BROAD = MBUS_CMD_WIDTH'(4);
  localparam logic [BROAD_TYPE_WIDTH-1:0] MESI_ISC_BREQ_TYPE_NOP     = '0;
  localparam logic [BROAD_TYPE_WIDTH-1:0] MESI_ISC_BREQ_TYPE_WR      = BROAD_TYPE_WIDTH'(1);
  localparam logic [BROAD_TYPE_WIDTH-1:0] MESI_ISC_BREQ_TYPE_RD      = BROAD_TYPE_WIDTH'(2);
  localparam logic [7:0]                  STARVE_MAX                 = 8'(STARVE_LIMIT);
  localparam logic [CPU_ID_WIDTH:0]       NUM_CPUS_W                 = (CPU_ID_WIDTH+1)'(NUM_CPUS);

  logic [NUM_CPUS-1:0]                        ack_q, ack_d;
  logic [NUM_CPUS-1:0][BROAD_TYPE_WIDTH-1:0]  type_q, type_d;
  logic [BASE_WIDTH-1:0]                      base_q, base_d;
  logic [CPU_ID_WIDTH-1:0]                    ptr_q, ptr_d;
  logic [NUM_CPUS-1:0][7:0]                   cnt_q, cnt_d;

  logic [NUM_CPUS-1:0]                        eligible, starved, rd;
  logic                                       any_eligible, grant_en, found;
  logic [CPU_ID_WIDTH-1:0]                    winner;
  logic [CPU_ID_WIDTH:0]                      rr_idx;
  logic [MBUS_CMD_WIDTH-1:0]                  cmd;
  logic [NUM_CPUS-1:0][CPU_ID_WIDTH-1:0]      cpu_id_w;
  logic [NUM_CPUS-1:0][BROAD_ID_WIDTH-1:0]    id_w;

  // Winner select: promoted channels first, then round-robin or fixed priority.
  always_comb begin
    eligible     = ~bus.fifo_status_empty_array_i;
    any_eligible = |eligible;
    grant_en     = ~bus.broad_fifo_status_full_i & any_eligible;
    starved      = '0;
    winner       = '0;
    found        = 1'b0;
    rr_idx       = '0;
    for (int unsigned i = 0; i < NUM_CPUS; i++)
      starved[i] = (cnt_q[i] == STARVE_MAX);
    for (int unsigned i = 0; i < NUM_CPUS; i++)
      if (!found && eligible[i] && starved[i]) begin
        winner = CPU_ID_WIDTH'(i);
        found  = 1'b1;
      end
    for (int unsigned k = 0; k < NUM_CPUS; k++) begin
      if (bus.arb_mode_i) begin
        rr_idx = (CPU_ID_WIDTH+1)'(k);
      end else begin
        rr_idx = {1'b0, ptr_q} + (CPU_ID_WIDTH+1)'(k);
        if (rr_idx >= NUM_CPUS_W) rr_idx = rr_idx - NUM_CPUS_W;
      end
      if (!found && eligible[rr_idx[CPU_ID_WIDTH-1:0]]) begin
        winner = rr_idx[CPU_ID_WIDTH-1:0];
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    rd     = '0;
    ack_d  = '0;
    type_d = '0;
    cnt_d  = cnt_q;
    cmd    = '0;
    for (int unsigned i = 0; i < NUM_CPUS; i++) begin
      rd[i]     = grant_en && (winner == CPU_ID_WIDTH'(i));
      cmd       = bus.mbus_cmd_array_i[i*MBUS_CMD_WIDTH +: MBUS_CMD_WIDTH];
      ack_d[i]  = ~ack_q[i] & ~bus.fifo_status_full_array_i[i] &
                  ((cmd == MESI_ISC_MBUS_CMD_WR_BROAD) || (cmd == MESI_ISC_MBUS_CMD_RD_BROAD));
      type_d[i] = (cmd == MESI_ISC_MBUS_CMD_WR_BROAD) ? MESI_ISC_BREQ_TYPE_WR :
                  (cmd == MESI_ISC_MBUS_CMD_RD_BROAD) ? MESI_ISC_BREQ_TYPE_RD :
                                                        MESI_ISC_BREQ_TYPE_NOP;
      if (!eligible[i] || rd[i])
        cnt_d[i] = '0;
      else if (grant_en && cnt_q[i] != STARVE_MAX)
        cnt_d[i] = cnt_q[i] + 8'd1;
    end
    base_d = (|ack_q) ? base_q + BASE_WIDTH'(1) : base_q;
    ptr_d  = ptr_q;
    if (grant_en)
      ptr_d = ({1'b0, winner} == NUM_CPUS_W - 1'b1) ? '0 : winner + CPU_ID_WIDTH'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_q  <= '0;
      type_q <= '0;
      base_q <= '0;
      ptr_q  <= '0;
      cnt_q  <= '0;
    end else begin
      ack_q  <= ack_d;
      type_q <= type_d;
      base_q <= base_d;
      ptr_q  <= ptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_comb begin
    cpu_id_w = '0;
    id_w     = '0;
    for (int unsigned i = 0; i < NUM_CPUS; i++) begin
      cpu_id_w[i] = CPU_ID_WIDTH'(i);
      id_w[i]     = {base_q, CPU_ID_WIDTH'(i)};
    end
  end

  assign bus.mbus_ack_array_o    = ack_q;
  assign bus.fifo_wr_array_o     = ack_q;
  assign bus.fifo_rd_array_o     = rd;
  assign bus.broad_fifo_wr_o     = |rd;
  assign bus.broad_addr_o        = any_eligible ? bus.broad_addr_array_i[winner*ADDR_WIDTH +: ADDR_WIDTH] : '0;
  assign bus.broad_type_o        = any_eligible ? bus.broad_type_array_i[winner*BROAD_TYPE_WIDTH +: BROAD_TYPE_WIDTH] : '0;
  assign bus.broad_id_o          = any_eligible ? bus.broad_id_array_i[winner*BROAD_ID_WIDTH +: BROAD_ID_WIDTH] : '0;
  assign bus.broad_cpu_id_o      = any_eligible ? winner : '0;
  assign bus.breq_type_array_o   = type_q;
  assign bus.breq_cpu_id_array_o = cpu_id_w;
  assign bus.breq_id_array_o     = id_w;
  assign bus.starved_o           = starved;
endmodule

// File: tb/tb_mesi_isc_breq_fifos_cntl_n.sv
// Randomized and directed bench for the breq FIFO bank controller against a
// cycle-level reference model of ack, tagging, arbitration and starvation rules.
module tb_mesi_isc_breq_fifos_cntl_n;
  localparam int unsigned N   = 4;
  localparam int unsigned CW  = 3;
  localparam int unsigned AW  = 32;
  localparam int unsigned TW  = 2;
  localparam int unsigned IW  = 4;
  localparam int unsigned CIW = 2;
  localparam int unsigned LIM = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mesi_isc_breq_fifos_cntl_n_if #(
    .NUM_CPUS(N), .MBUS_CMD_WIDTH(CW), .ADDR_WIDTH(AW),
    .BROAD_TYPE_WIDTH(TW), .BROAD_ID_WIDTH(IW)
  ) bus ();

  mesi_isc_breq_fifos_cntl_n #(
    .NUM_CPUS(N), .MBUS_CMD_WIDTH(CW), .ADDR_WIDTH(AW),
    .BROAD_TYPE_WIDTH(TW), .BROAD_ID_WIDTH(IW), .STARVE_LIMIT(LIM)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Stimulus for the current cycle
  int unsigned t_cmd[N], t_addr[N], t_type[N], t_id[N];
  bit          t_full[N], t_empty[N];
  bit          t_bfull, t_mode;

  // Reference model state
  bit          m_ack[N];
  int unsigned m_type[N], m_cnt[N];
  int unsigned m_base, m_ptr;

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      m_ack[i] = 1'b0; m_type[i] = 0; m_cnt[i] = 0;
    end
    m_base = 0; m_ptr = 0;
  endfunction

  // Winner: promoted channel first; else the eligible channel nearest after
  // the pointer (mode 0) or with the lowest index (mode 1). -1 when none.
  function automatic int pick();
    int best;
    int unsigned bestd, d;
    best = -1; bestd = N;
    for (int i = 0; i < N; i++)
      if (!t_empty[i] && m_cnt[i] == LIM) return i;
    for (int i = 0; i < N; i++)
      if (!t_empty[i]) begin
        d = t_mode ? i : (i + N - m_ptr) % N;
        if (d < bestd) begin bestd = d; best = i; end
      end
    return best;
  endfunction

  function automatic void drive();
    for (int i = 0; i < N; i++) begin
      bus.mbus_cmd_array_i[i*CW +: CW]   = CW'(t_cmd[i]);
      bus.broad_addr_array_i[i*AW +: AW] = t_addr[i];
      bus.broad_type_array_i[i*TW +: TW] = TW'(t_type[i]);
      bus.broad_id_array_i[i*IW +: IW]   = IW'(t_id[i]);
      bus.fifo_status_full_array_i[i]    = t_full[i];
      bus.fifo_status_empty_array_i[i]   = t_empty[i];
    end
    bus.broad_fifo_status_full_i = t_bfull;
    bus.arb_mode_i               = t_mode;
  endfunction

  task automatic check_all();
    int w;
    bit grant;
    logic [63:0] e_ack, e_rd, e_typ, e_cid, e_id, e_stv;
    w = pick();
    grant = !t_bfull && (w >= 0);
    e_ack = '0; e_typ = '0; e_cid = '0; e_id = '0; e_stv = '0;
    for (int i = 0; i < N; i++) begin
      e_ack[i] = m_ack[i];
      e_stv[i] = (m_cnt[i] == LIM);
      e_typ = e_typ | (64'(m_type[i]) << (i*TW));
      e_cid = e_cid | (64'(i) << (i*CIW));
      e_id  = e_id  | (64'(((m_base << CIW) | i) % (1 << IW)) << (i*IW));
    end
    e_rd = grant ? (64'd1 << w) : 64'd0;
    check("mbus_ack", 64'(bus.mbus_ack_array_o), e_ack);
    check("fifo_wr", 64'(bus.fifo_wr_array_o), e_ack);
    check("fifo_rd", 64'(bus.fifo_rd_array_o), e_rd);
    check("broad_wr", 64'(bus.broad_fifo_wr_o), 64'(grant));
    check("broad_addr", 64'(bus.broad_addr_o), (w >= 0) ? 64'(t_addr[w]) : 64'd0);
    check("broad_type", 64'(bus.broad_type_o), (w >= 0) ? 64'(t_type[w]) : 64'd0);
    check("broad_id", 64'(bus.broad_id_o), (w >= 0) ? 64'(t_id[w]) : 64'd0);
    check("broad_cpu_id", 64'(bus.broad_cpu_id_o), (w >= 0) ? 64'(w) : 64'd0);
    check("breq_type", 64'(bus.breq_type_array_o), e_typ);
    check("breq_cpu_id", 64'(bus.breq_cpu_id_array_o), e_cid);
    check("breq_id", 64'(bus.breq_id_array_o), e_id);
    check("starved", 64'(bus.starved_o), e_stv);
  endtask

  function automatic void model_step();
    int w;
    bit grant, any_ack;
    w = pick();
    grant = !t_bfull && (w >= 0);
    any_ack = 1'b0;
    for (int i = 0; i < N; i++) any_ack |= m_ack[i];
    if (any_ack) m_base = (m_base + 1) % (1 << (IW - CIW));
    for (int i = 0; i < N; i++) begin
      if (t_empty[i] || (grant && i == w)) m_cnt[i] = 0;
      else if (grant && m_cnt[i] < LIM)    m_cnt[i] = m_cnt[i] + 1;
      m_ack[i]  = !m_ack[i] && (t_cmd[i] == 3 || t_cmd[i] == 4) && !t_full[i];
      m_type[i] = (t_cmd[i] == 3) ? 1 : (t_cmd[i] == 4) ? 2 : 0;
    end
    if (grant) m_ptr = (w + 1) % N;
  endfunction

  // Entered at posedge+1: apply inputs, check mid-cycle, advance model.
  task automatic cycle();
    drive();
    #3;
    check_all();
    model_step();
    @(posedge clk);
    #1;
  endtask

  function automatic void set_quiet();
    for (int i = 0; i < N; i++) begin
      t_cmd[i] = 0; t_full[i] = 1'b0; t_empty[i] = 1'b1;
      t_addr[i] = 32'hA000_0000 + i * 32'h111; t_type[i] = (i + 1) % 4; t_id[i] = 8 + i;
    end
    t_bfull = 1'b0; t_mode = 1'b0;
  endfunction

  function automatic void set_empty(input logic [N-1:0] e);
    for (int i = 0; i < N; i++) t_empty[i] = e[i];
  endfunction

  initial begin
    rst_n = 1'b0;
    set_quiet();
    drive();
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    cycle();                               // reset state
    set_empty(4'b0000);
    drive(); #1;
    check("first_grant", 64'(bus.fifo_rd_array_o), 64'h1);
    cycle();

    // Ack/ID: held RD_BROAD on channel 0
    set_empty(4'b1111);
    t_cmd[0] = 4;
    drive(); #1;
    check("id_ch2_base0", 64'(bus.breq_id_array_o[2*IW +: IW]), 64'h2);
    repeat (6) cycle();
    t_full[0] = 1'b1;
    repeat (3) cycle();
    t_full[0] = 1'b0; t_cmd[0] = 0;

    // Round-robin between channels 1 and 3
    set_empty(4'b0101);
    repeat (6) cycle();

    // Backpressure then release
    set_empty(4'b0110);
    t_bfull = 1'b1;
    repeat (5) cycle();
    t_bfull = 1'b0;
    repeat (3) cycle();

    // Starvation in fixed-priority mode, channels 0 and 2 always pending
    t_mode = 1'b1;
    set_empty(4'b1010);
    t_cmd[1] = 3; t_cmd[3] = 4;
    repeat (10) cycle();

    // Mid-run asynchronous reset
    set_empty(4'b1111);
    drive();
    #2 rst_n = 1'b0;
    #1;
    check("rst_ack", 64'(bus.mbus_ack_array_o), 64'd0);
    check("rst_starved", 64'(bus.starved_o), 64'd0);
    check("rst_type", 64'(bus.breq_type_array_o), 64'd0);
    check("rst_rd", 64'(bus.fifo_rd_array_o), 64'd0);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    set_quiet();
    set_empty(4'b0000);
    cycle();

    // Random traffic
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        t_cmd[i]   = $urandom_range(0, 7);
        t_full[i]  = ($urandom_range(0, 3) == 0);
        t_empty[i] = ($urandom_range(0, 2) == 0);
        t_addr[i]  = $urandom;
        t_type[i]  = $urandom_range(0, 3);
        t_id[i]    = $urandom_range(0, 15);
      end
      t_bfull = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 15) == 0) t_mode = ~t_mode;
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
